// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential word fetch over a req/ack handshake,
// buffered with PCs in a show-ahead FIFO that feeds the decode stage.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stallD,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        validD,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pcplus4D
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DROP  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_run;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_drop_addr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W-1:0]   r_wptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_mem_instr [DEPTH];
    logic [31:0]        r_mem_pc    [DEPTH];

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_enter_drop;

    assign w_full = (r_count == CNT_W'(DEPTH));

    // Request never looks at imem_ack; only the next state does.
    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        imem_addr   = r_fetch_pc;
        case (r_state)
            ST_FETCH: begin
                imem_req  = r_run && !w_full;
                imem_addr = r_fetch_pc;
                if (flush && imem_req && !imem_ack)
                    w_state_nxt = ST_DROP;
            end
            ST_DROP: begin
                imem_req  = 1'b1;
                imem_addr = r_drop_addr;
                if (imem_ack)
                    w_state_nxt = ST_FETCH;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    assign w_enter_drop = (r_state == ST_FETCH) && (w_state_nxt == ST_DROP);
    assign w_push       = (r_state == ST_FETCH) && imem_req && imem_ack && !flush;
    assign w_pop        = validD && !stallD && !flush;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_FETCH;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    // The stale address keeps the abandoned request stable until it is acked.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else begin
            if (flush)
                r_fetch_pc <= {flush_pc[31:2], 2'b00};
            else if (w_push)
                r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_enter_drop)
                r_drop_addr <= r_fetch_pc;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_instr[r_wptr] <= imem_rdata;
            r_mem_pc[r_wptr]    <= r_fetch_pc;
        end
    end

    // Head is read straight out of storage; an empty queue presents a NOP.
    assign validD   = (r_count != '0);
    assign instrD   = validD ? r_mem_instr[r_rptr] : NOP;
    assign pcD      = validD ? r_mem_pc[r_rptr] : 32'h0;
    assign pcplus4D = validD ? (r_mem_pc[r_rptr] + 32'd4) : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed phases push expected PCs, a
// negedge monitor checks every popped head; a memory responder supplies acks.
module tb_fetch_queue;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stallD;
    logic        flush;
    logic [31:0] flush_pc;
    logic        validD;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcplus4D;

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    int n_xfer = 0;
    int p0;

    logic        force_ack;
    logic        man_mode;
    logic        man_ack;
    logic        man_junk;
    int          delay;
    int          wcnt;
    logic [31:0] held_addr;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stallD(stallD), .flush(flush), .flush_pc(flush_pc),
        .validD(validD), .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic load_exp(input logic [31:0] base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Memory responder: zero-wait or fixed wait states, or manual control.
    always @(negedge CLK) begin
        if (!RST_N) begin
            imem_ack   = force_ack;
            imem_rdata = 32'hBAD0_BAD0;
            wcnt       = 0;
        end else if (man_mode) begin
            imem_ack   = man_ack;
            imem_rdata = man_junk ? 32'hDEAD_BEEF : memword(imem_addr);
        end else if (imem_req) begin
            if (wcnt != 0) chk("addr_stable", imem_addr, held_addr);
            else held_addr = imem_addr;
            if (wcnt == delay) begin
                imem_ack   = 1'b1;
                imem_rdata = memword(imem_addr);
                wcnt       = 0;
            end else begin
                imem_ack   = 1'b0;
                wcnt       = wcnt + 1;
            end
        end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end
        if (RST_N && imem_req && imem_ack) n_xfer++;
    end

    // Monitor: every accepted head must match the front of the scoreboard.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (validD && !stallD && !flush) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL head_unexpected: got pc %h expected none", pcD);
                end else begin
                    e = exp_q.pop_front();
                    chk("head_pc", pcD, e);
                    chk("head_pc4", pcplus4D, e + 32'd4);
                    chk("head_instr", instrD, memword(e));
                end
            end else if (!validD) begin
                chk("empty_instr", instrD, 32'h0000_0013);
                chk("empty_pc", pcD, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; stallD = 1'b0; flush = 1'b0; flush_pc = 32'h0;
        force_ack = 1'b1; man_mode = 1'b0; man_ack = 1'b0; man_junk = 1'b0;
        delay = 0; imem_ack = 1'b0; imem_rdata = 32'h0;

        // Reset held with ack asserted
        repeat (3) begin
            step();
            chk("rst_req", {31'h0, imem_req}, 32'h0);
            chk("rst_addr", imem_addr, 32'h100);
            chk("rst_valid", {31'h0, validD}, 32'h0);
            chk("rst_instr", instrD, 32'h13);
            chk("rst_pc", pcD, 32'h0);
            chk("rst_pc4", pcplus4D, 32'h0);
        end
        load_exp(32'h100, 16);
        force_ack = 1'b0;
        RST_N = 1'b1;
        step();
        chk("rel_req", {31'h0, imem_req}, 32'h1);
        chk("rel_addr", imem_addr, 32'h100);
        chk("rel_valid", {31'h0, validD}, 32'h0);
        step();
        chk("first_valid", {31'h0, validD}, 32'h1);
        chk("first_pc", pcD, 32'h100);
        chk("first_pc4", pcplus4D, 32'h104);
        chk("first_addr", imem_addr, 32'h104);
        p0 = n_pop;
        repeat (10) step();
        chk("throughput", 32'(n_pop - p0), 32'd10);

        // Backpressure
        flush = 1'b1; flush_pc = 32'h1000; stallD = 1'b1;
        step();
        flush = 1'b0;
        load_exp(32'h1000, 16);
        n_xfer = 0;
        repeat (9) step();
        chk("bp_pushes", 32'(n_xfer), 32'd4);
        chk("bp_req", {31'h0, imem_req}, 32'h0);
        chk("bp_valid", {31'h0, validD}, 32'h1);
        chk("bp_head", pcD, 32'h1000);
        stallD = 1'b0;
        p0 = n_pop;
        repeat (12) step();
        chk("bp_drain", 32'(n_pop - p0), 32'd12);

        // Wait states (flush lands on a pending request, exercising DROP)
        flush = 1'b1; flush_pc = 32'h3000; delay = 3;
        step();
        flush = 1'b0;
        load_exp(32'h3000, 16);
        p0 = n_pop;
        for (int i = 0; i < 100 && (n_pop - p0) < 4; i++) step();
        chk("ws_pops", 32'(n_pop - p0), 32'd4);

        // Flush with pending request to 0x108
        RST_N = 1'b0; man_mode = 1'b1; man_ack = 1'b0; delay = 0; stallD = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        chk("mid_rst_valid", {31'h0, validD}, 32'h0);
        step();
        step();
        RST_N = 1'b1;
        step();
        man_ack = 1'b1;
        step();
        step();
        man_ack = 1'b0;
        step();
        chk("pend_addr", imem_addr, 32'h108);
        chk("pend_valid", {31'h0, validD}, 32'h1);
        chk("pend_head", pcD, 32'h100);
        flush = 1'b1; flush_pc = 32'h2000;
        step();
        flush = 1'b0; stallD = 1'b0;
        load_exp(32'h2000, 16);
        chk("drop_addr", imem_addr, 32'h108);
        chk("drop_req", {31'h0, imem_req}, 32'h1);
        chk("drop_valid", {31'h0, validD}, 32'h0);
        step();
        chk("drop_hold", imem_addr, 32'h108);
        man_ack = 1'b1; man_junk = 1'b1;
        step();
        chk("after_drop_addr", imem_addr, 32'h2000);
        chk("after_drop_valid", {31'h0, validD}, 32'h0);
        man_mode = 1'b0; man_ack = 1'b0; man_junk = 1'b0;
        step();
        chk("redir_valid", {31'h0, validD}, 32'h1);
        chk("redir_pc", pcD, 32'h2000);
        repeat (3) step();

        // Flush, ack and pop in the same cycle
        chk("pre_flush_valid", {31'h0, validD}, 32'h1);
        flush = 1'b1; flush_pc = 32'h4000;
        step();
        flush = 1'b0;
        load_exp(32'h4000, 16);
        chk("fap_valid", {31'h0, validD}, 32'h0);
        chk("fap_addr", imem_addr, 32'h4000);
        step();
        chk("fap_next_valid", {31'h0, validD}, 32'h1);
        chk("fap_next_pc", pcD, 32'h4000);
        repeat (2) step();

        // Wrap-around, then reset mid-stream
        flush = 1'b1; flush_pc = 32'hFFFF_FFF9;
        step();
        flush = 1'b0;
        load_exp(32'hFFFF_FFF8, 16);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFF8);
        p0 = n_pop;
        for (int i = 0; i < 20 && (n_pop - p0) < 4; i++) step();
        chk("wrap_pops", 32'(n_pop - p0), 32'd4);
        RST_N = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_req", {31'h0, imem_req}, 32'h0);
        chk("async_rst_addr", imem_addr, 32'h100);
        chk("async_rst_valid", {31'h0, validD}, 32'h0);
        chk("async_rst_instr", instrD, 32'h13);
        chk("async_rst_pc", pcD, 32'h0);
        chk("async_rst_pc4", pcplus4D, 32'h0);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that produces the instruction word consumed by the decode stage. It issues sequential word requests to instruction memory over a valid/acknowledge handshake and buffers the returned words with their PCs in a small show-ahead FIFO. Decode stalls apply backpressure, and execute-stage redirects (branches and jumps) flush the queue. It sits between the instruction memory port and the F/D boundary and supplies `instrD`, `pcD` and `pcplus4D`.

## Interface
- `DEPTH`, default 4: number of queue entries; must be a power of two and at least 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `CLK`  in  1: clock; all state updates on the rising edge.
- `RST_N`  in  1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `imem_req`  out  1: a request to instruction memory is active.
- `imem_addr`  out  32: word address of the active request; bits [1:0] are always 0.
- `imem_ack`  in  1: `imem_rdata` is valid for `imem_addr` this cycle; only meaningful while `imem_req`=1.
- `imem_rdata`  in  32: returned instruction word.
- `stallD`  in  1: decode cannot accept the head entry this cycle.
- `flush`  in  1: redirect request from execute.
- `flush_pc`  in  32: redirect target; bits [1:0] are ignored and treated as 0.
- `validD`  out  1: the head entry is valid.
- `instrD`  out  32: head instruction; 32'h0000_0013 (NOP) when the queue is empty.
- `pcD`  out  32: head PC; 0 when the queue is empty.
- `pcplus4D`  out  32: `pcD` + 4 (mod 2^32); 0 when the queue is empty.

## Operation
- **State:**
  - `fetch_pc` (32 bits).
  - FIFO of DEPTH entries {instr, pc}, with read pointer, write pointer and a count of width log2(DEPTH)+1.
  - FSM with states FETCH and DROP.
- **FETCH:**
  - `imem_req` = (count < DEPTH); `imem_addr` = `fetch_pc`.
  - A transfer occurs when `imem_req` and `imem_ack` are both 1. On a transfer, {`imem_rdata`, `fetch_pc`} is pushed and `fetch_pc` += 4.
- **Request stability:** once `imem_req` rises, `imem_req` and `imem_addr` hold until `imem_ack` is seen, even if the queue state changes.
- **Pop:** occurs when `validD` && !`stallD`; the head entry is removed.
- **Simultaneous push and pop:** both happen and the count is unchanged. A push into an empty queue is not visible on the outputs until the next cycle; there is no bypass.
- **Flush (highest priority):**
  - On the edge where `flush` is sampled, the queue empties (pointers and count go to 0), any same-cycle pop or push is discarded, and `fetch_pc` loads `flush_pc` & ~3.
  - If `imem_req`=1 and `imem_ack`=0 in the flush cycle, the FSM moves to DROP and records the pending address so the request stays stable.
  - If `imem_ack`=1 in the flush cycle, the returned word is discarded and the FSM stays in FETCH.
- **DROP:**
  - `imem_req`=1 and `imem_addr` = the recorded stale address.
  - When `imem_ack` arrives, the data is discarded and the FSM returns to FETCH, which requests `fetch_pc` in the following cycle.
  - A further `flush` while in DROP only reloads `fetch_pc`.
- **Wrap-around:** `fetch_pc` wraps from 32'hFFFF_FFFC to 0. The FIFO pointers wrap modulo DEPTH.

## Timing
- **Reset values (while `RST_N`=0):**
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `validD`=0, `instrD`=32'h13, `pcD`=0, `pcplus4D`=0.
  - FSM=FETCH, queue empty.
- **After reset:** `imem_req`=1 in the first cycle after `RST_N` rises.
- **Reset mid-operation:** a reset while a request is outstanding abandons it. The memory must tolerate the request being dropped; no response is consumed.
- **Latency:** an ack at edge t makes `validD`=1 with that word in the cycle after t.
- **Throughput:** with zero-wait memory, one instruction per cycle is sustained indefinitely.
- **Redirect penalty:** with zero-wait memory, a flush at edge t gives `imem_addr`=`flush_pc` in cycle t+1 and `validD`=1 at t+2.
- **Combinational outputs:** `imem_req` depends only on state and count, never on `imem_ack`. All D-side outputs are driven from the head register and FIFO state.

## Test plan
- **Reset:** hold `RST_N` low with `imem_ack`=1 → all outputs hold their reset values. Release with `RESET_PC`=0x100 and zero-wait memory → addresses 0x100, 0x104, …; `validD` rises 2 cycles after release with `pcD`=0x100 and `pcplus4D`=0x104.
- **Backpressure:** hold `stallD`=1 for 10 cycles with zero-wait memory → exactly DEPTH pushes, then `imem_req`=0. Release `stallD` → heads appear in order with no loss or duplication.
- **Wait states:** ack 3 cycles after each request → `imem_addr` is stable throughout; `validD` pulses once per word; PCs step by 4.
- **Flush with pending request:** flush to 0x2000 while a request to 0x0108 is un-acked → the FSM enters DROP and holds `imem_addr`=0x0108. Ack it → the data is discarded, then `imem_addr`=0x2000; the first valid head has `pcD`=0x2000.
- **Flush with ack and pop in the same cycle:** assert flush, ack and pop together → the queue is empty next cycle, the acked word is never seen, and the next request is to `flush_pc`.
- **Wrap-around and mid-stream reset:** start at 0xFFFF_FFF8 → heads are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Assert `RST_N`=0 mid-stream → outputs are immediately at reset values.
